// File: rtl/spatz_pkg.sv
// Shared Spatz types: VRF address/data words, fetch length and the VRF reader FSM states.
package spatz_pkg;

  localparam int unsigned NRVREG      = 32;
  localparam int unsigned VLEN        = 512;
  localparam int unsigned N_IPU       = 1;
  localparam int unsigned ELEN        = 64;
  localparam int unsigned VREG_WORDS  = NRVREG * VLEN / (N_IPU * ELEN);
  localparam int unsigned VREG_ADDR_W = $clog2(VREG_WORDS);
  localparam int unsigned VREG_DATA_W = N_IPU * ELEN;

  typedef logic [VREG_ADDR_W-1:0] vreg_addr_t;
  typedef logic [VREG_DATA_W-1:0] vreg_data_t;
  typedef logic [$clog2(NRVREG*VLEN/(N_IPU*ELEN)):0] vrf_len_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } vrf_reader_state_e;

  // Word carry flows into the register field (LMUL grouping); the top wraps modulo.
  function automatic vreg_addr_t vrf_word_addr(input vreg_addr_t base, input vrf_len_t idx);
    return base + vreg_addr_t'(idx);
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Registered FIFO (common_cells style) holding operand bundles; optional fall-through bypass.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 2,
  parameter type         dtype        = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  dtype              mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              push_s, pop_s, bypass_s;

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == FULL_CNT);
  assign bypass_s = FALL_THROUGH & empty_o & push_i & pop_i;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign push_s   = push_i & (~full_o | pop_i) & ~bypass_s;
  assign pop_s    = pop_i & ~empty_o;

  always_comb begin
    data_o = mem_q[rd_ptr_q];
    if (FALL_THROUGH && empty_o) begin
      data_o = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ADDR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ADDR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/spatz_vrf_reader.sv
// VRF operand fetch engine: per-word reads with conflict retry, bundles into a registered FIFO.
// Define SPATZ_VRF_READER_DRAIN_EN to hold off new commands until the previous one has drained.
module spatz_vrf_reader
  import spatz_pkg::*;
#(
  parameter int unsigned NR_OPERANDS = 3,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              cmd_valid_i,
  output logic                              cmd_ready_o,
  input  vreg_addr_t [NR_OPERANDS-1:0]      cmd_vs_i,
  input  logic       [NR_OPERANDS-1:0]      cmd_en_i,
  input  vrf_len_t                          cmd_len_i,
  output vreg_addr_t [NR_OPERANDS-1:0]      vrf_raddr_o,
  output logic       [NR_OPERANDS-1:0]      vrf_re_o,
  input  vreg_data_t [NR_OPERANDS-1:0]      vrf_rdata_i,
  input  logic       [NR_OPERANDS-1:0]      vrf_rvalid_i,
  output logic                              op_valid_o,
  input  logic                              op_ready_i,
  output vreg_data_t [NR_OPERANDS-1:0]      op_data_o,
  output logic                              op_last_o,
  output logic                              busy_o
);

  typedef struct packed {
    logic                         last;
    vreg_data_t [NR_OPERANDS-1:0] data;
  } bundle_t;

  vrf_reader_state_e            state_q, state_d;
  vreg_addr_t [NR_OPERANDS-1:0] vs_q, vs_d;
  logic       [NR_OPERANDS-1:0] en_q, en_d;
  logic       [NR_OPERANDS-1:0] got_q, got_d;
  vreg_data_t [NR_OPERANDS-1:0] staging_q, staging_d;
  vrf_len_t                     len_q, len_d;
  vrf_len_t                     idx_q, idx_d;

  logic       [NR_OPERANDS-1:0] cap_s;
  logic                         fifo_full_s, fifo_empty_s, fifo_pop_s;
  logic                         slot_free_s, word_done_s, last_word_s;
  logic                         cmd_hs_s, cmd_nonzero_s;
  bundle_t                      push_bundle_s, head_bundle_s;

  assign cmd_hs_s      = cmd_valid_i & cmd_ready_o;
  assign cmd_nonzero_s = (cmd_len_i != '0) & (|cmd_en_i);
  assign op_valid_o    = ~fifo_empty_s;
  assign fifo_pop_s    = op_valid_o & op_ready_i;
  assign slot_free_s   = ~fifo_full_s | fifo_pop_s;
  assign cap_s         = vrf_re_o & vrf_rvalid_i;
  assign last_word_s   = (idx_q == len_q - vrf_len_t'(1));
  assign word_done_s   = (state_q == FETCH) & slot_free_s & (((got_q | cap_s) & en_q) == en_q);
  assign op_data_o     = head_bundle_s.data;
  assign op_last_o     = head_bundle_s.last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_nonzero_s) state_d = FETCH;
        else                              state_d = IDLE;
      end
      FETCH: begin
        if (word_done_s && last_word_s) begin
`ifdef SPATZ_VRF_READER_DRAIN_EN
          state_d = DRAIN;
`else
          state_d = IDLE;
`endif
        end else begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (fifo_empty_s) state_d = IDLE;
        else              state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = (state_q == IDLE);
    busy_o      = (state_q != IDLE) | ~fifo_empty_s;
    for (int k = 0; k < int'(NR_OPERANDS); k++) begin
      vrf_raddr_o[k] = (state_q == FETCH) ? vrf_word_addr(vs_q[k], idx_q) : '0;
      vrf_re_o[k]    = (state_q == FETCH) & en_q[k] & ~got_q[k] & slot_free_s;
    end
  end

  // Same-cycle grants bypass staging so a conflict-free word completes in one cycle.
  always_comb begin
    push_bundle_s.last = last_word_s;
    for (int k = 0; k < int'(NR_OPERANDS); k++) begin
      if (!en_q[k])      push_bundle_s.data[k] = '0;
      else if (cap_s[k]) push_bundle_s.data[k] = vrf_rdata_i[k];
      else               push_bundle_s.data[k] = staging_q[k];
    end
  end

  always_comb begin
    vs_d      = vs_q;
    en_d      = en_q;
    len_d     = len_q;
    idx_d     = idx_q;
    got_d     = got_q;
    staging_d = staging_q;
    if (cmd_hs_s) begin
      vs_d  = cmd_vs_i;
      en_d  = cmd_en_i;
      len_d = cmd_len_i;
      idx_d = '0;
      got_d = '0;
    end else if (word_done_s) begin
      idx_d = idx_q + vrf_len_t'(1);
      got_d = '0;
    end else begin
      got_d = got_q | cap_s;
    end
    for (int k = 0; k < int'(NR_OPERANDS); k++) begin
      if (cap_s[k]) staging_d[k] = vrf_rdata_i[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_q      <= '0;
      en_q      <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      got_q     <= '0;
      staging_q <= '0;
    end else begin
      vs_q      <= vs_d;
      en_q      <= en_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      got_q     <= got_d;
      staging_q <= staging_d;
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (FIFO_DEPTH),
    .dtype        (bundle_t)
  ) i_bundle_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .data_i  (push_bundle_s),
    .push_i  (word_done_s),
    .data_o  (head_bundle_s),
    .pop_i   (fifo_pop_s)
  );

endmodule

// File: tb/tb_spatz_vrf_reader.sv
// Scoreboard bench for spatz_vrf_reader: directed test-plan cases, then randomized grants/backpressure.
`timescale 1ns/1ps
module tb_spatz_vrf_reader;
  import spatz_pkg::*;

  localparam int unsigned NOP = 3;
  localparam int unsigned FD  = 2;
  localparam int          ADDR_SPACE = 1 << VREG_ADDR_W;

  typedef struct packed {
    logic                 last;
    vreg_data_t [NOP-1:0] data;
  } exp_t;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  vreg_addr_t [NOP-1:0] cmd_vs_i;
  logic       [NOP-1:0] cmd_en_i;
  vrf_len_t             cmd_len_i;
  vreg_addr_t [NOP-1:0] vrf_raddr_o;
  logic       [NOP-1:0] vrf_re_o;
  vreg_data_t [NOP-1:0] vrf_rdata_i;
  logic       [NOP-1:0] vrf_rvalid_i;
  logic                 op_valid_o;
  logic                 op_ready_i;
  vreg_data_t [NOP-1:0] op_data_o;
  logic                 op_last_o;
  logic                 busy_o;

  int        checks = 0;
  int        failures = 0;
  exp_t      sb_q[$];
  longint    cyc = 0;
  longint    pop_cyc[$];
  logic      rand_mode = 1'b0;
  logic [NOP-1:0] dir_grant = '0, rnd_grant = '0;
  logic      dir_ready = 1'b0, rnd_ready = 1'b0;

  always #5 clk_i = ~clk_i;

  spatz_vrf_reader #(.NR_OPERANDS(NOP), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_vs_i(cmd_vs_i), .cmd_en_i(cmd_en_i), .cmd_len_i(cmd_len_i),
    .vrf_raddr_o(vrf_raddr_o), .vrf_re_o(vrf_re_o),
    .vrf_rdata_i(vrf_rdata_i), .vrf_rvalid_i(vrf_rvalid_i),
    .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
    .op_data_o(op_data_o), .op_last_o(op_last_o), .busy_o(busy_o)
  );

  // VRF contents: a unique word per (port, address).
  function automatic vreg_data_t model_word(input int k, input vreg_addr_t a);
    logic [7:0] kk;
    kk = 8'(k + 1);
    return {kk, a, 16'hA5C3, kk ^ a, a, 16'h5A3C ^ {a, a}};
  endfunction

  // Unrequested ports return junk, so stale or unguarded captures show up in the data.
  always_comb begin
    for (int k = 0; k < int'(NOP); k++) begin
      vrf_rdata_i[k] = vrf_re_o[k] ? model_word(k, vrf_raddr_o[k]) : {4{16'hDEAD}};
    end
  end

  assign vrf_rvalid_i = rand_mode ? rnd_grant : dir_grant;
  assign op_ready_i   = rand_mode ? rnd_ready : dir_ready;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    #1;
    rnd_grant = NOP'($urandom_range(0, 7));
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check_eq(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: word i of operand k is the VRF word at (vs[k] + i) mod address space.
  task automatic push_expected(input vreg_addr_t [NOP-1:0] vs, input logic [NOP-1:0] en, input int len);
    exp_t e;
    if (en == '0) return;
    for (int i = 0; i < len; i++) begin
      e.last = (i == len - 1);
      for (int k = 0; k < int'(NOP); k++) begin
        e.data[k] = en[k] ? model_word(k, vreg_addr_t'((int'(vs[k]) + i) % ADDR_SPACE)) : '0;
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic send_cmd(input vreg_addr_t [NOP-1:0] vs, input logic [NOP-1:0] en,
                          input int len, output int waited);
    int n;
    n = 0;
    @(posedge clk_i); #1;
    cmd_vs_i = vs; cmd_en_i = en; cmd_len_i = vrf_len_t'(len); cmd_valid_i = 1'b1;
    push_expected(vs, en, len);
    @(negedge clk_i);
    while (!cmd_ready_o && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    check_eq("cmd_accept_in_time", n < 400, 1);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    waited = n;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while ((busy_o || sb_q.size() != 0) && n < budget);
    check_eq("drain_in_time", n < budget, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, cmd_ready_o, 1);
    check_eq({tag, "_re"},        vrf_re_o, 0);
    check_eq({tag, "_raddr"},     vrf_raddr_o, 0);
    check_eq({tag, "_op_valid"},  op_valid_o, 0);
    check_eq({tag, "_op_data"},   op_data_o, 0);
    check_eq({tag, "_op_last"},   op_last_o, 0);
    check_eq({tag, "_busy"},      busy_o, 0);
  endtask

  // Monitor: pops the scoreboard on every bundle handshake and checks hold under backpressure.
  logic prev_stall = 1'b0;
  exp_t prev_b;
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni) begin
      if (prev_stall) begin
        check_eq("hold_valid", op_valid_o, 1);
        check_eq("hold_data", {op_last_o, op_data_o}, prev_b);
      end
      if (op_valid_o && op_ready_i) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_bundle", {op_last_o, op_data_o}, 0);
        end else begin
          e = sb_q.pop_front();
          check_eq("bundle", {op_last_o, op_data_o}, e);
        end
        pop_cyc.push_back(cyc);
      end
      prev_stall = op_valid_o && !op_ready_i;
      prev_b     = {op_last_o, op_data_o};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vreg_addr_t [NOP-1:0] vs;
    int t, n_words;
    cmd_valid_i = 1'b0; cmd_vs_i = '0; cmd_en_i = '0; cmd_len_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("rst");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Conflict-free fetch
    dir_ready = 1'b1; dir_grant = 3'b111;
    pop_cyc.delete();
    vs = {8'h60, 8'h40, 8'h20};
    send_cmd(vs, 3'b111, 4, t);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check_eq("t1_re", vrf_re_o, 3'b111);
      check_eq("t1_raddr0", vrf_raddr_o[0], 8'h20 + i);
      check_eq("t1_raddr2", vrf_raddr_o[2], 8'h60 + i);
    end
    @(negedge clk_i);
    check_eq("t1_re_done", vrf_re_o, 0);
    wait_idle(50);
    check_eq("t1_nbundles", pop_cyc.size(), 4);
    for (int i = 1; i < pop_cyc.size(); i++) begin
      check_eq("t1_back_to_back", pop_cyc[i] - pop_cyc[i-1], 1);
    end

    // Partial grant: port 1 denied for two cycles on word 0
    dir_grant = 3'b101;
    vs = {8'h50, 8'h10, 8'h30};
    send_cmd(vs, 3'b111, 2, t);
    @(negedge clk_i);
    check_eq("t2_re_c0", vrf_re_o, 3'b111);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("t2_re_c1", vrf_re_o, 3'b010);
    check_eq("t2_raddr1_c1", vrf_raddr_o[1], 8'h10);
    @(posedge clk_i); #1;
    dir_grant = 3'b111;
    @(negedge clk_i);
    check_eq("t2_re_c2", vrf_re_o, 3'b010);
    check_eq("t2_raddr1_c2", vrf_raddr_o[1], 8'h10);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("t2_re_c3", vrf_re_o, 3'b111);
    check_eq("t2_raddr0_c3", vrf_raddr_o[0], 8'h31);
    wait_idle(50);

    // Backpressure: FIFO fills with exactly FD bundles
    dir_ready = 1'b0;
    vs = {8'h00, 8'h88, 8'h77};
    send_cmd(vs, 3'b011, 5, t);
    n_words = 0;
    repeat (6) begin
      @(negedge clk_i);
      if ((vrf_re_o & vrf_rvalid_i) != 0) n_words++;
    end
    check_eq("t3_words_buffered", n_words, FD);
    check_eq("t3_re_stalled", vrf_re_o, 0);
    check_eq("t3_op_valid", op_valid_o, 1);
    @(posedge clk_i); #1;
    dir_ready = 1'b1;
    wait_idle(100);

    // Zero length, then zero enable
    send_cmd(vs, 3'b111, 0, t);
    check_eq("t4_len0_accept", t, 0);
    @(negedge clk_i);
    check_eq("t4_ready_after_len0", cmd_ready_o, 1);
    check_eq("t4_re_len0", vrf_re_o, 0);
    send_cmd(vs, 3'b000, 4, t);
    check_eq("t4_en0_accept", t, 0);
    repeat (3) begin
      @(negedge clk_i);
      check_eq("t4_re_idle", vrf_re_o, 0);
      check_eq("t4_valid_idle", op_valid_o, 0);
      check_eq("t4_busy_idle", busy_o, 0);
    end

    // Address wrap on operand 0 only
    vs = {8'h07, 8'h05, 8'hFF};
    send_cmd(vs, 3'b001, 2, t);
    @(negedge clk_i);
    check_eq("t5_re_w0", vrf_re_o, 3'b001);
    check_eq("t5_raddr_w0", vrf_raddr_o[0], 8'hFF);
    @(negedge clk_i);
    check_eq("t5_re_w1", vrf_re_o, 3'b001);
    check_eq("t5_raddr_w1", vrf_raddr_o[0], 8'h00);
    wait_idle(50);

    // Reset mid-command
    vs = {8'hC0, 8'hB0, 8'hA0};
    send_cmd(vs, 3'b111, 8, t);
    @(negedge clk_i);
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    sb_q.delete();
    @(negedge clk_i);
    check_reset_outputs("midrst");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    vs = {8'h1C, 8'h1B, 8'h1A};
    send_cmd(vs, 3'b111, 2, t);
    @(negedge clk_i);
    check_eq("t6_raddr0_idx0", vrf_raddr_o[0], 8'h1A);
    check_eq("t6_raddr2_idx0", vrf_raddr_o[2], 8'h1C);
    wait_idle(50);

    // Randomized commands, grants and consumer backpressure
    rand_mode = 1'b1;
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < int'(NOP); k++) vs[k] = vreg_addr_t'($urandom_range(0, ADDR_SPACE - 1));
      send_cmd(vs, NOP'($urandom_range(0, 7)), $urandom_range(0, 6), t);
    end
    wait_idle(3000);
    rand_mode = 1'b0;
    check_eq("final_sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
